free_ptr_pool: RTL and testbench
================================

Name: free_ptr_pool

Overview:
Parametrised successor to the shared-cache free-pointer FIFO. It manages the free list of cache cell addresses and fills itself after reset instead of relying on simulation-time preload. Depth does not have to be a power of two. Allocation and release each use a valid/ready handshake, and the block tracks ownership so illegal frees are rejected. It sits between the switch write-side (consumes pointers) and read-side (returns pointers).

Parameters:
NUM_PTR, 16, number of cache cells / pointers managed; any value >= 2.
PTR_BIT, $clog2(NUM_PTR), width of a pointer.
CNT_BIT, $clog2(NUM_PTR+1), width of the free-count output.
LOW_WM, 2, almost_empty threshold, in free pointers.

Ports:
clk  in  1  single clock; all logic on rising edge.
rst_n  in  1  reset, synchronous, active-low.
init_done  out  1  high once the free list is filled and the block is accepting traffic.
alloc_valid  out  1  a free pointer is available on alloc_ptr.
alloc_ready  in  1  consumer takes alloc_ptr this cycle.
alloc_ptr  out  PTR_BIT  head of the free list.
rel_valid  in  1  producer returns rel_ptr this cycle.
rel_ready  out  1  release accepted; equals init_done.
rel_ptr  in  PTR_BIT  pointer being freed.
free_cnt  out  CNT_BIT  number of free pointers.
almost_empty  out  1  free_cnt <= LOW_WM.
err  out  1  one-cycle pulse on a rejected release.
err_code  out  2  01 = out of range, 10 = double free; held until the next err.

Behaviour:
- Reset (rst_n=0 sampled at an edge):
  - state=INIT, fill_idx=0, rd_ptr=wr_ptr=0, free_cnt=0, in_use bitmap all 0.
  - init_done=0, alloc_valid=0, err=0, err_code=00.
- INIT state:
  - Each cycle writes mem[fill_idx]=fill_idx, then fill_idx+1.
  - After NUM_PTR writes: state=RUN, free_cnt=NUM_PTR, wr_ptr=0 (wrapped), init_done=1.
  - init_done rises exactly NUM_PTR cycles after the first cycle with rst_n=1.
  - Handshake inputs are ignored during INIT. rel_ready=0, alloc_valid=0.
- RUN state, allocation:
  - alloc_valid = (free_cnt != 0).
  - alloc_ptr = mem[rd_ptr], combinational from storage with zero latency. Its value is don't-care when alloc_valid=0.
  - Fire = alloc_valid & alloc_ready. On fire: rd_ptr advances, in_use[alloc_ptr] is set, free_cnt decrements.
- RUN state, release:
  - Legal = rel_valid & (rel_ptr < NUM_PTR) & in_use[rel_ptr], with in_use as registered before this edge.
  - Legal release: mem[wr_ptr]=rel_ptr, wr_ptr advances, in_use[rel_ptr] is cleared, free_cnt increments.
  - Illegal release: no storage or count change. err=1 for one cycle. err_code=01 if rel_ptr >= NUM_PTR, else 10.
- Pointer wrap: rd_ptr and wr_ptr go NUM_PTR-1 -> 0. There is no power-of-two assumption.
- Simultaneous alloc fire and legal release in one cycle:
  - Both take effect and free_cnt is unchanged.
  - This is allowed with free_cnt=0 only if alloc_valid=0. In that case only the release occurs, and the released pointer appears on alloc_ptr next cycle.
- Releasing the pointer being allocated in the same cycle is a double free (its in_use bit is not yet set): err_code=10. The allocation still completes.
- Overflow is impossible by construction: legal releases are bounded by in_use count, and free_cnt never exceeds NUM_PTR.
- almost_empty is combinational from registered free_cnt.
- Reset asserted mid-operation: the next edge returns to the INIT reset values and the full re-fill sequence runs. All outstanding pointers are forgotten.

Test Plan:
1. NUM_PTR=6, release reset -> init_done=0 for 6 cycles, then 1; free_cnt=6, alloc_valid=1, alloc_ptr=0.
2. NUM_PTR=6, alloc_ready held 1 for 7 cycles -> alloc_ptr sequence 0,1,2,3,4,5, then alloc_valid=0, free_cnt=0, almost_empty=1 (LOW_WM=2 and it is already 1 at free_cnt=2).
3. After test 2, release 3 then 1 -> free_cnt 1 then 2; next allocs return 3 then 1, which checks the wrap from index 5 to 0.
4. Release 4 while 4 is free -> err pulse 1 cycle, err_code=10, free_cnt unchanged. Release 7 (NUM_PTR=6) -> err_code=01.
5. free_cnt=3, one cycle with alloc fire (ptr a) and legal release of ptr b -> free_cnt stays 3, in_use[a]=1, in_use[b]=0, b allocated after the 2 older entries.
6. Allocate 4 pointers, assert rst_n=0 for 1 cycle -> init_done=0 and a 6-cycle refill. Then release of any pointer -> err_code=10, and free_cnt=6.

Source files
------------

// File: rtl/free_ptr_pool.sv
// free_ptr_pool
// Free-list manager for shared-cache cell addresses. After reset it fills its
// own storage with 0..NUM_PTR-1 and then hands pointers out on the alloc
// handshake. It takes them back on the release handshake. A per-pointer
// ownership bitmap rejects releases of pointers that are out of range or that
// are not currently allocated.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   init_done    free list filled, block accepting traffic
//   alloc_valid  a free pointer is presented on alloc_ptr
//   alloc_ready  consumer takes alloc_ptr this cycle
//   alloc_ptr    head of the free list (combinational read)
//   rel_valid    producer returns rel_ptr this cycle
//   rel_ready    release accepted (same as init_done)
//   rel_ptr      pointer being freed
//   free_cnt     number of free pointers
//   almost_empty free_cnt <= LOW_WM
//   err          one-cycle pulse on a rejected release
//   err_code     01 = out of range, 10 = double free; held until next err
module free_ptr_pool #(
  parameter int NUM_PTR = 16,
  parameter int PTR_BIT = $clog2(NUM_PTR),
  parameter int CNT_BIT = $clog2(NUM_PTR + 1),
  parameter int LOW_WM  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               init_done,
  output logic               alloc_valid,
  input  logic               alloc_ready,
  output logic [PTR_BIT-1:0] alloc_ptr,
  input  logic               rel_valid,
  output logic               rel_ready,
  input  logic [PTR_BIT-1:0] rel_ptr,
  output logic [CNT_BIT-1:0] free_cnt,
  output logic               almost_empty,
  output logic               err,
  output logic [1:0]         err_code
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [PTR_BIT-1:0] LAST_IDX = PTR_BIT'(NUM_PTR - 1);
  localparam logic [CNT_BIT-1:0] FULL_CNT = CNT_BIT'(NUM_PTR);
  localparam logic [CNT_BIT-1:0] WM_CNT   = CNT_BIT'(LOW_WM);

  localparam logic [1:0] ERR_RANGE  = 2'b01;
  localparam logic [1:0] ERR_DOUBLE = 2'b10;

  // Circular pointer storage; read asynchronously so the head is visible
  // in the same cycle it becomes valid.
  logic [PTR_BIT-1:0] r_mem [NUM_PTR];

  logic [0:0]         r_state;
  logic [PTR_BIT-1:0] r_fill_idx;
  logic [PTR_BIT-1:0] r_rd_ptr;
  logic [PTR_BIT-1:0] r_wr_ptr;
  logic [CNT_BIT-1:0] r_free_cnt;
  logic [NUM_PTR-1:0] r_in_use;
  logic [NUM_PTR-1:0] w_in_use_next;
  logic               r_err;
  logic [1:0]         r_err_code;

  logic               w_run;
  logic               w_alloc_fire;
  logic               w_rel_in_range;
  logic [PTR_BIT-1:0] w_rel_idx;
  logic               w_rel_legal;
  logic               w_rel_reject;
  logic               w_mem_we;
  logic [PTR_BIT-1:0] w_mem_waddr;
  logic [PTR_BIT-1:0] w_mem_wdata;

  // Ring pointers wrap at NUM_PTR-1, so depth need not be a power of two.
  function automatic logic [PTR_BIT-1:0] f_next_ptr(input logic [PTR_BIT-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  assign w_run        = (r_state == ST_RUN);
  assign init_done    = w_run;
  assign rel_ready    = w_run;
  assign alloc_valid  = w_run && (r_free_cnt != '0);
  assign alloc_ptr    = r_mem[r_rd_ptr];
  assign free_cnt     = r_free_cnt;
  assign almost_empty = (r_free_cnt <= WM_CNT);
  assign err          = r_err;
  assign err_code     = r_err_code;

  assign w_alloc_fire = alloc_valid & alloc_ready;

  // Widen before comparing so the range test stays meaningful when
  // NUM_PTR is a power of two.
  assign w_rel_in_range = (CNT_BIT'(rel_ptr) < FULL_CNT);
  // Keep the bitmap index inside the array for out-of-range requests.
  assign w_rel_idx      = w_rel_in_range ? rel_ptr : '0;
  // Ownership is judged on the bitmap as it stood before this edge, so
  // returning the pointer being allocated right now counts as a double free.
  assign w_rel_legal    = w_run & rel_valid & w_rel_in_range & r_in_use[w_rel_idx];
  assign w_rel_reject   = w_run & rel_valid & ~w_rel_legal;

  // One write port shared by the fill sequence and the release path.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = r_wr_ptr;
    w_mem_wdata = rel_ptr;
    if (rst_n) begin
      if (!w_run) begin
        w_mem_we    = 1'b1;
        w_mem_waddr = r_fill_idx;
        w_mem_wdata = r_fill_idx;
      end else if (w_rel_legal) begin
        w_mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  // Ownership bitmap: a freshly allocated pointer is free beforehand and a
  // legally released one is owned, so set and clear never hit the same bit.
  for (genvar gi = 0; gi < NUM_PTR; gi++) begin : g_in_use
    logic w_set;
    logic w_clr;
    assign w_set = w_alloc_fire && (alloc_ptr == PTR_BIT'(gi));
    assign w_clr = w_rel_legal && (rel_ptr == PTR_BIT'(gi));
    assign w_in_use_next[gi] = w_set ? 1'b1 : (w_clr ? 1'b0 : r_in_use[gi]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_in_use <= '0;
    end else begin
      r_in_use <= w_in_use_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_INIT;
      r_fill_idx <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_free_cnt <= '0;
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
    end else if (r_state == ST_INIT) begin
      r_err <= 1'b0;
      if (r_fill_idx == LAST_IDX) begin
        r_state    <= ST_RUN;
        r_fill_idx <= '0;
        r_free_cnt <= FULL_CNT;
      end else begin
        r_fill_idx <= r_fill_idx + 1'b1;
      end
    end else begin
      if (w_alloc_fire) begin
        r_rd_ptr <= f_next_ptr(r_rd_ptr);
      end
      if (w_rel_legal) begin
        r_wr_ptr <= f_next_ptr(r_wr_ptr);
      end
      // Simultaneous alloc and release leave the count unchanged.
      case ({w_alloc_fire, w_rel_legal})
        2'b10:   r_free_cnt <= r_free_cnt - 1'b1;
        2'b01:   r_free_cnt <= r_free_cnt + 1'b1;
        default: r_free_cnt <= r_free_cnt;
      endcase
      r_err <= w_rel_reject;
      if (w_rel_reject) begin
        r_err_code <= w_rel_in_range ? ERR_DOUBLE : ERR_RANGE;
      end
    end
  end

endmodule

// File: tb/tb_free_ptr_pool.sv
module tb_free_ptr_pool;

  localparam int NP = 6;
  localparam int PB = 3;
  localparam int CB = 3;
  localparam int LW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          init_done;
  logic          alloc_valid;
  logic          alloc_ready = 1'b0;
  logic [PB-1:0] alloc_ptr;
  logic          rel_valid = 1'b0;
  logic          rel_ready;
  logic [PB-1:0] rel_ptr = '0;
  logic [CB-1:0] free_cnt;
  logic          almost_empty;
  logic          err;
  logic [1:0]    err_code;

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected allocation order, plus which pointers the bench
  // believes are handed out.
  int          exp_q[$];
  bit [NP-1:0] exp_in_use;

  free_ptr_pool #(.NUM_PTR(NP), .LOW_WM(LW)) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_ptr(alloc_ptr),
    .rel_valid(rel_valid), .rel_ready(rel_ready), .rel_ptr(rel_ptr),
    .free_cnt(free_cnt), .almost_empty(almost_empty),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  // Pop side of the scoreboard: every accepted allocation must match the head.
  always @(negedge clk) begin
    int p;
    if (rst_n && init_done && alloc_valid && alloc_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL alloc_unexpected got=%0d required=none", alloc_ptr);
      end else begin
        p = exp_q.pop_front();
        exp_in_use[p] = 1'b1;
        if (alloc_ptr !== p[PB-1:0]) begin
          errors++;
          $display("FAIL alloc_ptr got=%0d required=%0d", alloc_ptr, p);
        end else begin
          $display("alloc ptr=%0d", alloc_ptr);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < NP; i++) exp_q.push_back(i);
    exp_in_use = '0;
  endtask

  // Drive a release and push it to the scoreboard if the bench deems it legal.
  task automatic drive_rel(input int p, output bit legal);
    rel_valid = 1'b1;
    rel_ptr   = p[PB-1:0];
    legal     = (p < NP) && exp_in_use[p];
    if (legal) begin
      exp_q.push_back(p);
      exp_in_use[p] = 1'b0;
    end
    $display("release ptr=%0d legal=%0d", p, legal);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({init_done, alloc_valid, rel_ready, err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got=%b required=0000", {init_done, alloc_valid, rel_ready, err});
    end
    checks++;
    if ({free_cnt, err_code} !== 5'b0) begin
      errors++;
      $display("FAIL reset_cnt_code got=%0d/%0d required=0/0", free_cnt, err_code);
    end
    // Handshake traffic during the fill must be ignored.
    rst_n = 1'b1; alloc_ready = 1'b1; rel_valid = 1'b1; rel_ptr = 3'd2;
    for (int i = 1; i <= NP; i++) begin
      tick();
      if (i == NP - 1) begin alloc_ready = 1'b0; rel_valid = 1'b0; end
      checks++;
      if ({init_done, alloc_valid, rel_ready, err} !== {{3{i == NP}}, 1'b0}) begin
        errors++;
        $display("FAIL init_seq cycle=%0d got=%b required=%b", i,
                 {init_done, alloc_valid, rel_ready, err}, {{3{i == NP}}, 1'b0});
      end
    end
    model_reset();
    checks++;
    if (free_cnt !== 3'd6 || alloc_ptr !== 3'd0 || almost_empty !== 1'b0) begin
      errors++;
      $display("FAIL init_state got cnt=%0d ptr=%0d ae=%b required cnt=6 ptr=0 ae=0",
               free_cnt, alloc_ptr, almost_empty);
    end
  endtask

  task automatic test_drain();
    alloc_ready = 1'b1;
    for (int i = 0; i <= NP; i++) begin
      checks++;
      if (free_cnt !== CB'(NP - i) || alloc_valid !== (i < NP) || almost_empty !== ((NP - i) <= LW)) begin
        errors++;
        $display("FAIL drain step=%0d got cnt=%0d v=%b ae=%b required cnt=%0d v=%b ae=%b",
                 i, free_cnt, alloc_valid, almost_empty, NP - i, i < NP, (NP - i) <= LW);
      end
      tick();
    end
    alloc_ready = 1'b0;
    checks++;
    if (free_cnt !== 3'd0 || alloc_valid !== 1'b0 || almost_empty !== 1'b1) begin
      errors++;
      $display("FAIL drain_end got cnt=%0d v=%b ae=%b required 0 0 1", free_cnt, alloc_valid, almost_empty);
    end
  endtask

  task automatic test_release_wrap();
    bit legal;
    drive_rel(3, legal);
    tick();
    checks++;
    if (free_cnt !== 3'd1 || err !== 1'b0 || alloc_valid !== 1'b1 || alloc_ptr !== 3'd3) begin
      errors++;
      $display("FAIL rel3 got cnt=%0d err=%b v=%b ptr=%0d required 1 0 1 3", free_cnt, err, alloc_valid, alloc_ptr);
    end
    drive_rel(1, legal);
    tick();
    rel_valid = 1'b0;
    checks++;
    if (free_cnt !== 3'd2) begin
      errors++;
      $display("FAIL rel1_cnt got=%0d required=2", free_cnt);
    end
    alloc_ready = 1'b1;
    repeat (2) tick();
    alloc_ready = 1'b0;
    checks++;
    if (free_cnt !== 3'd0) begin
      errors++;
      $display("FAIL realloc_cnt got=%0d required=0", free_cnt);
    end
  endtask

  task automatic test_errors();
    int   ptrs[5]  = '{4, 4, 7, 6, -1};
    bit   e_err[5] = '{0, 1, 1, 1, 0};
    int   e_code[5] = '{0, 2, 1, 1, 1};
    bit   legal;
    for (int k = 0; k < 5; k++) begin
      if (ptrs[k] >= 0) drive_rel(ptrs[k], legal);
      else rel_valid = 1'b0;
      tick();
      checks++;
      if (err !== e_err[k] || err_code !== 2'(e_code[k]) || free_cnt !== 3'd1) begin
        errors++;
        $display("FAIL err_step=%0d got err=%b code=%0d cnt=%0d required err=%b code=%0d cnt=1",
                 k, err, err_code, free_cnt, e_err[k], e_code[k]);
      end
    end
  endtask

  task automatic test_simultaneous();
    bit legal;
    drive_rel(0, legal); tick();
    drive_rel(2, legal); tick();
    rel_valid = 1'b0;
    checks++;
    if (free_cnt !== 3'd3) begin
      errors++;
      $display("FAIL simul_pre got=%0d required=3", free_cnt);
    end
    // Allocate 4 while releasing 5 in the same cycle.
    alloc_ready = 1'b1;
    drive_rel(5, legal);
    tick();
    alloc_ready = 1'b0;
    checks++;
    if (free_cnt !== 3'd3 || err !== 1'b0) begin
      errors++;
      $display("FAIL simul_cnt got cnt=%0d err=%b required cnt=3 err=0", free_cnt, err);
    end
    drive_rel(5, legal);
    tick();
    checks++;
    if (err !== 1'b1 || err_code !== 2'b10 || free_cnt !== 3'd3) begin
      errors++;
      $display("FAIL simul_b_free got err=%b code=%0d cnt=%0d required 1 2 3", err, err_code, free_cnt);
    end
    drive_rel(4, legal);
    tick();
    rel_valid = 1'b0;
    checks++;
    if (err !== 1'b0 || free_cnt !== 3'd4) begin
      errors++;
      $display("FAIL simul_a_owned got err=%b cnt=%0d required err=0 cnt=4", err, free_cnt);
    end
    alloc_ready = 1'b1;
    repeat (3) tick();
    alloc_ready = 1'b0;
    checks++;
    if (free_cnt !== 3'd1 || alloc_ptr !== 3'd4) begin
      errors++;
      $display("FAIL simul_end got cnt=%0d ptr=%0d required cnt=1 ptr=4", free_cnt, alloc_ptr);
    end
  endtask

  task automatic test_back_to_back();
    int order[NP] = '{2, 5, 0, 4, 1, 3};
    bit legal;
    // Release the very pointer being allocated: double free, alloc still completes.
    alloc_ready = 1'b1;
    drive_rel(4, legal);
    tick();
    checks++;
    if (err !== 1'b1 || err_code !== 2'b10 || free_cnt !== 3'd0 || alloc_valid !== 1'b0) begin
      errors++;
      $display("FAIL same_ptr got err=%b code=%0d cnt=%0d v=%b required 1 2 0 0",
               err, err_code, free_cnt, alloc_valid);
    end
    // Empty list: only the release takes effect, pointer shows up next cycle.
    drive_rel(4, legal);
    tick();
    rel_valid = 1'b0;
    checks++;
    if (err !== 1'b0 || free_cnt !== 3'd1 || alloc_valid !== 1'b1 || alloc_ptr !== 3'd4) begin
      errors++;
      $display("FAIL empty_rel got err=%b cnt=%0d v=%b ptr=%0d required 0 1 1 4",
               err, free_cnt, alloc_valid, alloc_ptr);
    end
    tick();
    alloc_ready = 1'b0;
    for (int k = 0; k < NP; k++) begin
      drive_rel(order[k], legal);
      tick();
      checks++;
      if (free_cnt !== CB'(k + 1) || err !== 1'b0) begin
        errors++;
        $display("FAIL b2b_rel k=%0d got cnt=%0d err=%b required cnt=%0d err=0", k, free_cnt, err, k + 1);
      end
    end
    rel_valid = 1'b0;
    alloc_ready = 1'b1;
    repeat (NP) tick();
    alloc_ready = 1'b0;
    checks++;
    if (free_cnt !== 3'd0 || almost_empty !== 1'b1) begin
      errors++;
      $display("FAIL b2b_alloc_end got cnt=%0d ae=%b required 0 1", free_cnt, almost_empty);
    end
  endtask

  task automatic test_random();
    bit legal;
    int exp_code = 2;
    bit exp_err;
    int p;
    for (int n = 0; n < 200; n++) begin
      alloc_ready = 1'($urandom_range(0, 1));
      exp_err = 1'b0;
      if ($urandom_range(0, 2) != 0) begin
        p = $urandom_range(0, 7);
        drive_rel(p, legal);
        if (!legal) begin
          exp_err  = 1'b1;
          exp_code = (p >= NP) ? 1 : 2;
        end
      end else begin
        rel_valid = 1'b0;
      end
      tick();
      checks++;
      if (err !== exp_err || err_code !== 2'(exp_code) || free_cnt !== CB'(exp_q.size())
          || alloc_valid !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL random n=%0d got err=%b code=%0d cnt=%0d v=%b required err=%b code=%0d cnt=%0d",
                 n, err, err_code, free_cnt, alloc_valid, exp_err, exp_code, exp_q.size());
      end
    end
    alloc_ready = 1'b0;
    rel_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit legal;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (NP) tick();
    model_reset();
    alloc_ready = 1'b1;
    repeat (4) tick();
    alloc_ready = 1'b0;
    checks++;
    if (free_cnt !== 3'd2 || almost_empty !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre got cnt=%0d ae=%b required 2 1", free_cnt, almost_empty);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({init_done, alloc_valid, rel_ready, err, err_code, free_cnt} !== 9'b0) begin
      errors++;
      $display("FAIL mid_reset got=%b required=0", {init_done, alloc_valid, rel_ready, err, err_code, free_cnt});
    end
    rst_n = 1'b1;
    for (int i = 1; i <= NP; i++) begin
      tick();
      checks++;
      if (init_done !== (i == NP)) begin
        errors++;
        $display("FAIL mid_refill cycle=%0d got=%b required=%b", i, init_done, i == NP);
      end
    end
    model_reset();
    drive_rel(1, legal);
    tick();
    rel_valid = 1'b0;
    checks++;
    if (err !== 1'b1 || err_code !== 2'b10 || free_cnt !== 3'd6) begin
      errors++;
      $display("FAIL mid_forgotten got err=%b code=%0d cnt=%0d required 1 2 6", err, err_code, free_cnt);
    end
  endtask

  initial begin
    exp_in_use = '0;
    test_reset();
    test_drain();
    test_release_wrap();
    test_errors();
    test_simultaneous();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
